// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: boot clear, load-use bubbles,
// branch flushes and data-memory freeze. Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rR1_i,
    input  logic [4:0]  id_rR2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_wr_i,
    input  logic        ex_is_load_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_suspend_o,
    output logic        if_id_flush_o,
    output logic        id_exe_suspend_o,
    output logic        id_exe_flush_o,
    output logic        exe_mem_suspend_o,
    output logic        mem_wb_flush_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic        err_o
);

    localparam int unsigned BOOT_W = 4;
    localparam int unsigned WAIT_W = 8;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TO_LAST   = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_e;

    state_e              state_q, state_d;
    logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic                load_use;
    logic                freeze;
    logic                resolve;

    assign load_use = ex_is_load_i && (ex_wr_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rR1_i == ex_wr_i)) ||
                       (id_use_rs2_i && (id_rR2_i == ex_wr_i)));
    assign freeze   = mem_req_i && !mem_ready_i;
    assign err_o    = err_q;

    // Next-state and combinational pipeline-control outputs
    always_comb begin
        state_d           = state_q;
        boot_cnt_d        = boot_cnt_q;
        wait_cnt_d        = wait_cnt_q;
        pend_d            = pend_q;
        err_d             = err_q;
        resolve           = 1'b0;
        pc_stall_o        = 1'b0;
        if_id_suspend_o   = 1'b0;
        if_id_flush_o     = 1'b0;
        id_exe_suspend_o  = 1'b0;
        id_exe_flush_o    = 1'b0;
        exe_mem_suspend_o = 1'b0;
        mem_wb_flush_o    = 1'b0;

        case (state_q)
            BOOT: begin
                pc_stall_o     = 1'b1;
                if_id_flush_o  = 1'b1;
                id_exe_flush_o = 1'b1;
                mem_wb_flush_o = 1'b1;
                if (boot_cnt_q >= BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                    if (branch_taken_i) pend_d = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready_i) begin
                    if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_d >= TO_LAST) err_d = 1'b1;
                    if (branch_taken_i) pend_d = 1'b1;
                end else begin
                    state_d = RUN;
                    resolve = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase

        // Everything outside BOOT that is not resolving is frozen on the memory access
        if ((state_q != BOOT) && !resolve) begin
            pc_stall_o        = 1'b1;
            if_id_suspend_o   = 1'b1;
            id_exe_suspend_o  = 1'b1;
            exe_mem_suspend_o = 1'b1;
            mem_wb_flush_o    = 1'b1;
        end

        // Branch squashes the ID instruction, so it outranks load-use
        if (resolve) begin
            if (branch_taken_i || pend_q) begin
                if_id_flush_o  = 1'b1;
                id_exe_flush_o = 1'b1;
                pend_d         = 1'b0;
            end else if (load_use) begin
                pc_stall_o      = 1'b1;
                if_id_suspend_o = 1'b1;
                id_exe_flush_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // BOOT cycles drive stall/flush but are not hazards, so they are excluded
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != BOOT) begin
            if (pc_stall_o)     stall_cnt_q <= stall_cnt_q + 32'd1;
            if (id_exe_flush_o) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (BOOT_CYCLES=2, TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rR1, id_rR2, ex_wr;
    logic       use_rs1, use_rs2, ex_load, br, mreq, mrdy;
    logic       pc_stall, ifid_sus, ifid_fl, idex_sus, idex_fl, exm_sus, mwb_fl, err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    // {pc_stall, if_id_susp, if_id_flush, id_exe_susp, id_exe_flush, exe_mem_susp, mem_wb_flush, err}
    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [7:0] BOOTV = 8'hAA;
    localparam logic [7:0] FRZ  = 8'hD6;
    localparam logic [7:0] BR   = 8'h28;
    localparam logic [7:0] LU   = 8'hC8;
    localparam logic [7:0] ERR  = 8'h01;

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .id_rR1_i         (id_rR1),
        .id_rR2_i         (id_rR2),
        .id_use_rs1_i     (use_rs1),
        .id_use_rs2_i     (use_rs2),
        .ex_wr_i          (ex_wr),
        .ex_is_load_i     (ex_load),
        .branch_taken_i   (br),
        .mem_req_i        (mreq),
        .mem_ready_i      (mrdy),
        .pc_stall_o       (pc_stall),
        .if_id_suspend_o  (ifid_sus),
        .if_id_flush_o    (ifid_fl),
        .id_exe_suspend_o (idex_sus),
        .id_exe_flush_o   (idex_fl),
        .exe_mem_suspend_o(exm_sus),
        .mem_wb_flush_o   (mwb_fl),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt),
`endif
        .err_o            (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] observed();
        return {pc_stall, ifid_sus, ifid_fl, idex_sus, idex_fl, exm_sus, mwb_fl, err};
    endfunction

    task automatic idle_inputs();
        id_rR1 = 5'd0; id_rR2 = 5'd0; ex_wr = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; ex_load = 1'b0;
        br = 1'b0; mreq = 1'b0; mrdy = 1'b0;
    endtask

    // Drive one cycle's inputs (already set), queue expectation, compare mid-cycle, advance
    task automatic step(input logic [7:0] exp, input string tag);
        logic [7:0] e;
        string      t;
        logic [7:0] o;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_lu(input logic [4:0] wr, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
        ex_load = 1'b1; ex_wr = wr;
        id_rR1 = r1; use_rs1 = u1; id_rR2 = r2; use_rs2 = u2;
    endtask

    task automatic boot_seq(input string tag);
        rst = 1'b1;
        step(BOOTV, {tag, "_in_reset"});
        rst = 1'b0;
        step(BOOTV, {tag, "_boot0"});
        br = 1'b1; mreq = 1'b1; mrdy = 1'b0;
        step(BOOTV, {tag, "_boot1_ignores_hazards"});
        step(IDLE, {tag, "_run_idle"});
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        boot_seq("boot");

        set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        step(LU, "lu_rs2");
        step(IDLE, "lu_after_bubble");
        set_lu(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        step(IDLE, "lu_x0_no_stall");
        set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        step(IDLE, "lu_rs1_unused");
        set_lu(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
        step(LU, "lu_rs1");
        ex_load = 1'b0; ex_wr = 5'd7; id_rR1 = 5'd7; use_rs1 = 1'b1;
        step(IDLE, "no_load_no_stall");

        mreq = 1'b1; br = 1'b1;
        step(FRZ, "freeze_with_branch");
        mreq = 1'b1;
        step(FRZ, "freeze_wait1");
        mreq = 1'b1;
        step(FRZ, "freeze_wait2");
        mreq = 1'b1; mrdy = 1'b1;
        step(BR, "ready_pending_flush");
        step(IDLE, "pending_cleared");

        br = 1'b1;
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        step(BR, "branch_beats_lu");

        mreq = 1'b1;
        step(FRZ, "to_freeze");
        for (int i = 1; i <= 3; i++) begin
            mreq = 1'b1;
            step(FRZ, $sformatf("to_wait%0d", i));
        end
        mreq = 1'b1;
        step(FRZ | ERR, "to_err_rises");
        mreq = 1'b1;
        step(FRZ | ERR, "to_err_holds");
        mreq = 1'b1; mrdy = 1'b1;
        step(ERR, "to_ready_err_sticky");
        step(ERR, "err_sticky_idle");
        mreq = 1'b1;
        step(FRZ | ERR, "freeze2");
        mreq = 1'b1; mrdy = 1'b1;
        set_lu(5'd4, 5'd0, 1'b0, 5'd4, 1'b1);
        step(LU | ERR, "ready_with_lu");

        mreq = 1'b1;
        step(FRZ | ERR, "freeze3");
        mreq = 1'b1;
        step(FRZ | ERR, "freeze3_wait");
        mreq = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        assert ({err, pc_stall, idex_fl} === 3'b011) else begin
            errors++;
            $error("FAIL async_reset_midwait: observed %b expected %b", {err, pc_stall, idex_fl}, 3'b011);
        end
        boot_seq("reboot");

        set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        step(LU, "perf_lu1");
        step(IDLE, "perf_gap");
        set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
        step(LU, "perf_lu2");
        br = 1'b1;
        step(BR, "perf_branch");
`ifdef HAZ_PERF_CNT_EN
        checks++;
        assert (stall_cnt === 32'd2) else begin
            errors++;
            $error("FAIL stall_cnt: observed %0d expected %0d", stall_cnt, 2);
        end
        checks++;
        assert (flush_cnt === 32'd3) else begin
            errors++;
            $error("FAIL flush_cnt: observed %0d expected %0d", flush_cnt, 3);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the suspend and flush inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers, plus the PC stall.
- Resolves load-use hazards, taken-branch flushes and data-memory wait states, and runs a post-reset pipeline-clear sequence.
- Data forwarding is handled elsewhere; this block only inserts stalls and bubbles.

Parameters:
- BOOT_CYCLES, 2, cycles after reset release during which every stage is flushed and the PC is held (legal range 1..15).
- TIMEOUT, 64, MEM_WAIT cycles without mem_ready_i before err_o is set (legal range 2..255).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- id_rR1_i  in  5  rs1 index of the instruction in ID.
- id_rR2_i  in  5  rs2 index of the instruction in ID.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_wr_i  in  5  destination register of the instruction in EX.
- ex_is_load_i  in  1  EX instruction is a load.
- branch_taken_i  in  1  EX resolved a taken branch or jump this cycle.
- mem_req_i  in  1  MEM stage is issuing a data-memory access.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_stall_o  out  1  hold the PC.
- if_id_suspend_o  out  1  hold IF/ID.
- if_id_flush_o  out  1  clear IF/ID.
- id_exe_suspend_o  out  1  hold ID/EXE.
- id_exe_flush_o  out  1  clear ID/EXE (insert bubble).
- exe_mem_suspend_o  out  1  hold EXE/MEM.
- mem_wb_flush_o  out  1  insert bubble into WB.
- err_o  out  1  sticky memory-timeout error.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- State register: BOOT, RUN, MEM_WAIT. Also a 4-bit boot counter, an 8-bit wait counter and a pending_flush flag.
- Reset: state=BOOT, boot counter=0, wait counter=0, pending_flush=0, err_o=0.
- Outputs are combinational from state, flags and inputs. While rst_i is high, BOOT values apply:
  - pc_stall_o=1, if_id_flush_o=1, id_exe_flush_o=1, mem_wb_flush_o=1.
  - All suspends=0.
- Reset asserted mid-operation (any state) returns immediately to BOOT and drops pending_flush.
- BOOT:
  - BOOT values are driven for exactly BOOT_CYCLES clock edges after reset release, then state goes to RUN.
  - All hazard inputs are ignored.
- RUN, evaluated in priority order:
  1. Freeze: mem_req_i=1 && mem_ready_i=0.
     - pc_stall_o, if_id_suspend_o, id_exe_suspend_o, exe_mem_suspend_o = 1; mem_wb_flush_o=1; all other outputs 0.
     - Next state MEM_WAIT; wait counter cleared to 0.
     - If branch_taken_i=1 in this cycle, set pending_flush=1.
  2. Branch: branch_taken_i=1 (or pending_flush=1).
     - if_id_flush_o=1, id_exe_flush_o=1; clear pending_flush.
     - The PC is not stalled (the redirect comes from EX).
  3. Load-use: ex_is_load_i=1 && ex_wr_i!=0 && ((id_use_rs1_i && id_rR1_i==ex_wr_i) || (id_use_rs2_i && id_rR2_i==ex_wr_i)).
     - pc_stall_o=1, if_id_suspend_o=1, id_exe_flush_o=1.
     - Exactly one bubble; the next cycle has no hazard from the same pair.
  4. Otherwise all outputs 0.
- MEM_WAIT:
  - Freeze outputs are held while mem_ready_i=0.
  - Wait counter increments each cycle and saturates at 255.
  - When the counter reaches TIMEOUT-1, err_o is set. It stays set until reset; waiting continues regardless.
  - The cycle mem_ready_i=1: freeze is dropped and RUN priorities 2-4 apply in the same cycle (pending_flush included). Next state RUN.
- Register index x0 never causes a load-use stall.
- A branch and a load-use in the same cycle: the branch wins (the ID instruction is squashed anyway).

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0]. Both reset to 0 and wrap at 2^32.
  - stall_cnt_o +1 on every RUN/MEM_WAIT cycle with pc_stall_o=1.
  - flush_cnt_o +1 on every RUN/MEM_WAIT cycle with id_exe_flush_o=1.
  - BOOT cycles are not counted.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, BOOT_CYCLES=2, idle inputs -> flush/stall outputs are 1 for exactly 2 edges after release, then all 0; err_o=0.
- ex_is_load_i=1, ex_wr_i=5, id_rR2_i=5, id_use_rs2_i=1 -> one cycle of pc_stall_o=1, if_id_suspend_o=1, id_exe_flush_o=1. Repeat with ex_wr_i=0 -> no stall.
- mem_req_i=1, mem_ready_i=0 for 3 cycles together with branch_taken_i=1 in the first cycle -> 3 freeze cycles, then on the ready cycle if_id_flush_o=1 and id_exe_flush_o=1 (pending branch applied).
- branch_taken_i=1 in the same cycle as a load-use match -> if_id_flush_o=1, id_exe_flush_o=1, pc_stall_o=0.
- TIMEOUT=4, mem_ready_i held 0 -> err_o rises on the 4th MEM_WAIT cycle and stays 1 after ready; rst_i pulse mid-wait -> BOOT, err_o=0.
- HAZ_PERF_CNT_EN defined, two load-use stalls plus one branch -> stall_cnt_o=2, flush_cnt_o=3.
